// File: rtl/tr_pkg.sv
// tr_pkg: constants and types shared by the tracking front-end blocks.
package tr_pkg;
    localparam int DATA_W      = 36;
    localparam int TIMEOUT_DEF = 1000;
    typedef enum logic {RUN, FAULT} avg_state_t;
endpackage

// File: rtl/adc_watchdog.sv
// adc_watchdog: counts cycles since the last adc_valid and pulses timeout when the count reaches TIMEOUT.
module adc_watchdog #(
    parameter int TIMEOUT = tr_pkg::TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic adc_valid,
    output logic timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;
    // Fires on the cycle whose edge moves timer onto TIMEOUT, so the fault lands exactly TIMEOUT edges after the last sample.
    assign timeout = !adc_valid && timer == TW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst || adc_valid)
            timer <= '0;
        else if (timer != TW'(TIMEOUT))
            timer <= timer + TW'(1);
    end
endmodule

// File: rtl/adc_avg.sv
// adc_avg: boxcar averager over 2^AVG_LOG2 ADC samples with flush and stall detection.
module adc_avg #(
    parameter int DATA_W   = tr_pkg::DATA_W,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = tr_pkg::TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              flush,
    output logic [DATA_W-1:0] x,
    output logic              data_valid,
    output logic              adc_fault
);
    localparam int CW = AVG_LOG2 == 0 ? 1 : AVG_LOG2;
    localparam int AW = DATA_W + AVG_LOG2;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
    tr_pkg::avg_state_t state, state_nxt;
    logic [AW-1:0] acc, acc_base, sum;
    logic [CW-1:0] cnt, cnt_base;
    logic timeout, fault_entry, win_done;
    adc_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk       (clk),
        .rst       (rst),
        .adc_valid (adc_valid),
        .timeout   (timeout)
    );
    always_comb begin
        fault_entry = state == tr_pkg::RUN && timeout;
        state_nxt   = fault_entry ? tr_pkg::FAULT
                    : (state == tr_pkg::FAULT && adc_valid) ? tr_pkg::RUN : state;
        // A flush in the same cycle as a sample makes that sample the first of a fresh window.
        acc_base    = flush ? '0 : acc;
        cnt_base    = flush ? '0 : cnt;
        sum         = acc_base + AW'(adc_data);
        win_done    = adc_valid && cnt_base == LAST;
    end
    assign adc_fault = state == tr_pkg::FAULT;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= tr_pkg::RUN;
            acc        <= '0;
            cnt        <= '0;
            x          <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_valid <= win_done;
            if (win_done) begin
                x   <= DATA_W'(sum >> AVG_LOG2);
                acc <= '0;
                cnt <= '0;
            end else if (adc_valid) begin
                acc <= sum;
                cnt <= cnt_base + CW'(1);
            end else if (flush || fault_entry) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end
endmodule

// File: doc/adc_avg.md
# adc_avg

Boxcar averaging front-end for the tracking controller. It takes raw 36-bit ADC samples, each arriving with a one-cycle strobe. It emits one decimated average per window of 2^AVG_LOG2 samples as `x` with a `data_valid` strobe, and these two outputs drive the `x` and `data_valid` inputs of TR directly. It also watches the ADC for stalls and flags a fault so the tracking loop never acts on a stale window.

## Interface
Parameters:
- `DATA_W`, 36: sample and output width.
- `AVG_LOG2`, 2: log2 of the window length (4 samples). Legal range 0..8.
- `TIMEOUT`, 1000: number of clk cycles without `adc_valid` before `adc_fault` asserts. Minimum 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  50 MHz system clock.
- `rst`  in  1  synchronous, active-high reset.
- `adc_valid`  in  1  one-cycle strobe; `adc_data` is valid in this cycle.
- `adc_data`  in  DATA_W  unsigned ADC sample.
- `flush`  in  1  discards the partial window.
- `x`  out  DATA_W  last averaged value; held between updates.
- `data_valid`  out  1  one-cycle strobe; `x` is new in this cycle.
- `adc_fault`  out  1  ADC stall flag.

## Operation
- **Accumulator `acc`:** unsigned, DATA_W+AVG_LOG2 bits, so it never overflows.
- **Window counter `cnt`:** AVG_LOG2 bits (or 1 bit when AVG_LOG2=0).
- **On `adc_valid` with `cnt` < 2^AVG_LOG2−1:**
  - `acc` <= `acc` + `adc_data`
  - `cnt` <= `cnt` + 1
- **On `adc_valid` with `cnt` = 2^AVG_LOG2−1 (window-completing sample):**
  - `x` <= (`acc` + `adc_data`) >> AVG_LOG2, truncated toward zero.
  - `data_valid` <= 1 for exactly one cycle.
  - `acc` <= 0 and `cnt` <= 0.
- **AVG_LOG2=0:** pass-through with one register stage.
- **`flush`:** clears `acc` and `cnt`; `x` holds.
  - `flush` and `adc_valid` in the same cycle: flush wins, and that sample becomes the first sample of the new window (`acc` = `adc_data`, `cnt` = 1).
- **Watchdog `timer`:** counts cycles since the last `adc_valid`, saturates at TIMEOUT, and resets to 0 on every `adc_valid`.
- **FSM states:**
  - RUN: normal accumulation.
  - FAULT: entered when `timer` reaches TIMEOUT in RUN. On entry `adc_fault` <= 1 and `acc`/`cnt` are cleared. `x` holds and `data_valid` stays 0.
  - FAULT → RUN on the next `adc_valid`: `adc_fault` <= 0 in that same clock edge, and the sample starts a new window (`cnt` = 1).
- **Reset values:** `x` = 0, `data_valid` = 0, `adc_fault` = 0, `acc` = 0, `cnt` = 0, `timer` = 0, state RUN.
  - The watchdog runs from reset, so a dead ADC faults TIMEOUT cycles after reset is released.

## Timing
- **Latency:** `data_valid` and the new `x` appear one cycle after the edge that samples the window-completing `adc_valid`. No combinational path runs from inputs to outputs.
- **Throughput:** one sample per cycle is supported (back-to-back `adc_valid`). At the system rate (one sample every 5 cycles, AVG_LOG2=2) the output rate is one `data_valid` every 20 cycles.
- **`data_valid`:** never high on two consecutive cycles unless AVG_LOG2=0 and `adc_valid` is continuous.
- **Fault timing:** `adc_fault` rises exactly TIMEOUT cycles after the edge that sampled the last `adc_valid`.
- **`rst` mid-window:** the partial window is lost. `rst` has priority over `flush` and `adc_valid`.

## Structure
- Shared package `tr_pkg`: the `DATA_W` constant (36), shared by TR, TR_pulse and this block, and the default TIMEOUT value.
- One sub-module, `adc_watchdog`: holds `timer`, the saturation logic and a `timeout` pulse output. The FSM and datapath stay in `adc_avg`.

## Test plan
- **Steady input:** after reset, 30000 on every 5th cycle with AVG_LOG2=2 → `x` = 30000 with `data_valid` one cycle after each 4th sample, then every 20 cycles; `adc_fault` stays 0.
- **Truncation:** samples 1, 2, 3, 5 → `x` = 2 (11>>2); next window 4, 4, 4, 4 → `x` = 4.
- **Full-scale:** four samples of 2^36−1 back-to-back → `x` = 2^36−1, no wrap; `data_valid` high for exactly one cycle.
- **Flush:** two samples of 7, then `flush` together with a sample of 100, then three more samples of 100 → exactly one `data_valid`, with `x` = 100.
- **Stall:** stop `adc_valid` after 2 samples with TIMEOUT=1000 → `adc_fault` = 1 at cycle 1000 with `x` unchanged; then four samples of 50 → fault clears on the first of them and `x` = 50.
- **Reset mid-window:** `rst` after 3 samples → all outputs 0; the next `data_valid` requires 4 fresh samples.
